// File: rtl/multi_cycle_control_unit.sv
// rtl/multi_cycle_control_unit.sv - multi-cycle RV32I control FSM with halt flag and retired-instruction counter
module multi_cycle_control_unit #(
    parameter int INSTRET_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [6:0]               opcode,
    input  logic                     halt_cond,
    input  logic                     alu_bcond,
    input  logic                     mem_ready,
    output logic                     pc_write,
    output logic                     pc_write_cond,
    output logic                     pc_source,
    output logic                     iord,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic                     ir_write,
    output logic [1:0]               mem_to_reg,
    output logic                     reg_write,
    output logic [1:0]               alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [1:0]               alu_op,
    output logic                     is_halted,
    output logic [INSTRET_WIDTH-1:0] instret
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [INSTRET_WIDTH-1:0] INSTRET_ONE = {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    logic [INSTRET_WIDTH-1:0] instret_q, instret_d;
    logic                     halted_q, halted_d;
    logic                     retire;

    // The branch decision is ANDed with pc_write_cond in the datapath, not here.
    logic unused_bcond;
    assign unused_bcond = alu_bcond;

    // State, retired counter and sticky halt flag; reset clears all three at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IF;
            instret_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            halted_q  <= halted_d;
        end
    end

    // Next state and control outputs; reset forces every control to 0 so a pending access aborts immediately.
    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 2'b00;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;

        case (state_q)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                if (opcode == OP_SYSTEM) begin
                    if (halt_cond) begin
                        state_d = S_HALT;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_IF;
                    end
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                case (opcode)
                    OP_RTYPE: begin
                        alu_src_a = 2'b01;
                        alu_op    = 2'b10;
                        state_d   = S_WB;
                    end
                    OP_IARITH: begin
                        alu_src_a = 2'b01;
                        alu_src_b = 2'b10;
                        alu_op    = 2'b10;
                        state_d   = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a = 2'b01;
                        alu_src_b = 2'b10;
                        state_d   = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_a     = 2'b01;
                        alu_op        = 2'b01;
                        pc_write_cond = 1'b1;
                        pc_source     = 1'b1;
                        retire        = 1'b1;
                        state_d       = S_IF;
                    end
                    OP_JAL: begin
                        reg_write  = 1'b1;
                        mem_to_reg = 2'b10;
                        pc_write   = 1'b1;
                        pc_source  = 1'b1;
                        retire     = 1'b1;
                        state_d    = S_IF;
                    end
                    OP_JALR: begin
                        alu_src_a  = 2'b01;
                        alu_src_b  = 2'b10;
                        reg_write  = 1'b1;
                        mem_to_reg = 2'b10;
                        pc_write   = 1'b1;
                        retire     = 1'b1;
                        state_d    = S_IF;
                    end
                    default: begin
                        retire  = 1'b1;
                        state_d = S_IF;
                    end
                endcase
            end
            S_MEM: begin
                iord = 1'b1;
                if (opcode == OP_LOAD) begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        state_d = S_WB;
                    end
                end else begin
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        retire  = 1'b1;
                        state_d = S_IF;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
                retire     = 1'b1;
                state_d    = S_IF;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IF;
            end
        endcase

        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_source     = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 2'b00;
            reg_write     = 1'b0;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
        end
    end

    // Counter and halt-flag next values; a halting ECALL sets the flag without retiring.
    always_comb begin
        instret_d = retire ? (instret_q + INSTRET_ONE) : instret_q;
        halted_d  = halted_q | ((state_q == S_ID) && (state_d == S_HALT));
    end

    assign is_halted = halted_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb/tb_multi_cycle_control_unit.sv - table-driven self-checking bench for multi_cycle_control_unit
module tb_multi_cycle_control_unit;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_JL = 7'b1101111;
    localparam logic [6:0] OP_JR = 7'b1100111;
    localparam logic [6:0] OP_EC = 7'b1110011;
    localparam logic [6:0] OP_XX = 7'b0000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        halt_cond;
    logic        alu_bcond;
    logic        mem_ready;

    logic        pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0]  mem_to_reg, alu_src_a, alu_src_b, alu_op;
    logic        is_halted;
    logic [31:0] instret;

    logic        w_pc_write, w_pc_write_cond, w_pc_source, w_iord, w_mem_read, w_mem_write, w_ir_write, w_reg_write;
    logic [1:0]  w_mem_to_reg, w_alu_src_a, w_alu_src_b, w_alu_op;
    logic        w_is_halted;
    logic [1:0]  w_instret;

    multi_cycle_control_unit #(.INSTRET_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .halt_cond(halt_cond),
        .alu_bcond(alu_bcond), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .is_halted(is_halted), .instret(instret)
    );

    // Narrow counter copy shares the stimulus so wraparound is exercised within a short run.
    multi_cycle_control_unit #(.INSTRET_WIDTH(2)) dut_wrap (
        .clk(clk), .reset(reset), .opcode(opcode), .halt_cond(halt_cond),
        .alu_bcond(alu_bcond), .mem_ready(mem_ready),
        .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond), .pc_source(w_pc_source),
        .iord(w_iord), .mem_read(w_mem_read), .mem_write(w_mem_write), .ir_write(w_ir_write),
        .mem_to_reg(w_mem_to_reg), .reg_write(w_reg_write), .alu_src_a(w_alu_src_a),
        .alu_src_b(w_alu_src_b), .alu_op(w_alu_op), .is_halted(w_is_halted), .instret(w_instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [6:0]  opc;
        logic        hc;
        logic        bc;
        logic        mr;
        logic [16:0] ctl;
        logic [31:0] ir_cnt;
    } step_t;

    step_t tbl[$];
    int    total = 0;
    int    bad   = 0;

    function automatic logic [16:0] mk(input logic pcw, input logic pcwc, input logic pcs,
                                       input logic io, input logic mr, input logic mw,
                                       input logic irw, input logic [1:0] mtr, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic h);
        return {pcw, pcwc, pcs, io, mr, mw, irw, mtr, rw, a, b, op, h};
    endfunction

    logic [16:0] c_zero, c_if_wait, c_if_done, c_id, c_ex_r, c_ex_i, c_ex_ls, c_ex_br;
    logic [16:0] c_ex_jal, c_ex_jalr, c_mem_ld, c_mem_st, c_wb_alu, c_wb_ld, c_halt;
    logic [16:0] got_ctl;

    assign got_ctl = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, is_halted};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic add(input string n, input logic r, input logic [6:0] o, input logic h,
                       input logic b, input logic m, input logic [16:0] c, input logic [31:0] i);
        step_t s;
        s.name = n; s.rst = r; s.opc = o; s.hc = h; s.bc = b; s.mr = m; s.ctl = c; s.ir_cnt = i;
        tbl.push_back(s);
    endtask

    // Drives one row just after a rising edge, checks before the next one, then advances a clock.
    task automatic run_row(input step_t s);
        reset = s.rst; opcode = s.opc; halt_cond = s.hc; alu_bcond = s.bc; mem_ready = s.mr;
        #3;
        check({s.name, ".ctl"}, {15'd0, got_ctl}, {15'd0, s.ctl});
        check({s.name, ".instret"}, instret, s.ir_cnt);
        check({s.name, ".instret_w2"}, {30'd0, w_instret}, {30'd0, s.ir_cnt[1:0]});
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              pcw pcwc pcs io  mr  mw  irw mtr    rw  a      b      op     h
        c_zero    = mk(0,  0,   0,  0,  0,  0,  0,  2'b00, 0,  2'b00, 2'b00, 2'b00, 0);
        c_if_wait = mk(0,  0,   0,  0,  1,  0,  0,  2'b00, 0,  2'b00, 2'b01, 2'b00, 0);
        c_if_done = mk(1,  0,   0,  0,  1,  0,  1,  2'b00, 0,  2'b00, 2'b01, 2'b00, 0);
        c_id      = mk(0,  0,   0,  0,  0,  0,  0,  2'b00, 0,  2'b10, 2'b10, 2'b00, 0);
        c_ex_r    = mk(0,  0,   0,  0,  0,  0,  0,  2'b00, 0,  2'b01, 2'b00, 2'b10, 0);
        c_ex_i    = mk(0,  0,   0,  0,  0,  0,  0,  2'b00, 0,  2'b01, 2'b10, 2'b10, 0);
        c_ex_ls   = mk(0,  0,   0,  0,  0,  0,  0,  2'b00, 0,  2'b01, 2'b10, 2'b00, 0);
        c_ex_br   = mk(0,  1,   1,  0,  0,  0,  0,  2'b00, 0,  2'b01, 2'b00, 2'b01, 0);
        c_ex_jal  = mk(1,  0,   1,  0,  0,  0,  0,  2'b10, 1,  2'b00, 2'b00, 2'b00, 0);
        c_ex_jalr = mk(1,  0,   0,  0,  0,  0,  0,  2'b10, 1,  2'b01, 2'b10, 2'b00, 0);
        c_mem_ld  = mk(0,  0,   0,  1,  1,  0,  0,  2'b00, 0,  2'b00, 2'b00, 2'b00, 0);
        c_mem_st  = mk(0,  0,   0,  1,  0,  1,  0,  2'b00, 0,  2'b00, 2'b00, 2'b00, 0);
        c_wb_alu  = mk(0,  0,   0,  0,  0,  0,  0,  2'b00, 1,  2'b00, 2'b00, 2'b00, 0);
        c_wb_ld   = mk(0,  0,   0,  0,  0,  0,  0,  2'b01, 1,  2'b00, 2'b00, 2'b00, 0);
        c_halt    = mk(0,  0,   0,  0,  0,  0,  0,  2'b00, 0,  2'b00, 2'b00, 2'b00, 1);

        add("reset",      1, OP_I,  0, 0, 1, c_zero,    0);
        add("addi.if",    0, OP_I,  0, 0, 1, c_if_done, 0);
        add("addi.id",    0, OP_I,  0, 0, 1, c_id,      0);
        add("addi.ex",    0, OP_I,  0, 0, 1, c_ex_i,    0);
        add("addi.wb",    0, OP_I,  0, 0, 1, c_wb_alu,  0);
        add("ld.if_wait", 0, OP_LD, 0, 0, 0, c_if_wait, 1);
        add("ld.if",      0, OP_LD, 0, 0, 1, c_if_done, 1);
        add("ld.id",      0, OP_LD, 0, 0, 1, c_id,      1);
        add("ld.ex",      0, OP_LD, 0, 0, 0, c_ex_ls,   1);
        add("ld.mem0",    0, OP_LD, 0, 0, 0, c_mem_ld,  1);
        add("ld.mem1",    0, OP_LD, 0, 0, 0, c_mem_ld,  1);
        add("ld.mem2",    0, OP_LD, 0, 0, 0, c_mem_ld,  1);
        add("ld.mem3",    0, OP_LD, 0, 0, 1, c_mem_ld,  1);
        add("ld.wb",      0, OP_LD, 0, 0, 1, c_wb_ld,   1);
        add("brt.if",     0, OP_BR, 0, 1, 1, c_if_done, 2);
        add("brt.id",     0, OP_BR, 0, 1, 1, c_id,      2);
        add("brt.ex",     0, OP_BR, 0, 1, 1, c_ex_br,   2);
        add("brn.if",     0, OP_BR, 0, 0, 1, c_if_done, 3);
        add("brn.id",     0, OP_BR, 0, 0, 1, c_id,      3);
        add("brn.ex",     0, OP_BR, 0, 0, 1, c_ex_br,   3);
        add("st.if",      0, OP_ST, 0, 0, 1, c_if_done, 4);
        add("st.id",      0, OP_ST, 0, 0, 1, c_id,      4);
        add("st.ex",      0, OP_ST, 0, 0, 1, c_ex_ls,   4);
        add("st.mem0",    0, OP_ST, 0, 0, 0, c_mem_st,  4);
        add("st.mem1",    0, OP_ST, 0, 0, 1, c_mem_st,  4);
        add("r.if",       0, OP_R,  0, 0, 1, c_if_done, 5);
        add("r.id",       0, OP_R,  0, 0, 1, c_id,      5);
        add("r.ex",       0, OP_R,  0, 0, 1, c_ex_r,    5);
        add("r.wb",       0, OP_R,  0, 0, 1, c_wb_alu,  5);
        add("jal.if",     0, OP_JL, 0, 0, 1, c_if_done, 6);
        add("jal.id",     0, OP_JL, 0, 0, 1, c_id,      6);
        add("jal.ex",     0, OP_JL, 0, 0, 1, c_ex_jal,  6);
        add("jalr.if",    0, OP_JR, 0, 0, 1, c_if_done, 7);
        add("jalr.id",    0, OP_JR, 0, 0, 1, c_id,      7);
        add("jalr.ex",    0, OP_JR, 0, 0, 1, c_ex_jalr, 7);
        add("nop.if",     0, OP_XX, 0, 0, 1, c_if_done, 8);
        add("nop.id",     0, OP_XX, 0, 0, 1, c_id,      8);
        add("nop.ex",     0, OP_XX, 0, 0, 1, c_zero,    8);
        add("ec0.if",     0, OP_EC, 0, 0, 1, c_if_done, 9);
        add("ec0.id",     0, OP_EC, 0, 0, 1, c_id,      9);
        add("ec1.if",     0, OP_EC, 1, 0, 1, c_if_done, 10);
        add("ec1.id",     0, OP_EC, 1, 0, 1, c_id,      10);

        reset = 1'b1; opcode = OP_I; halt_cond = 1'b0; alu_bcond = 1'b0; mem_ready = 1'b1;
        #1;
        foreach (tbl[i]) run_row(tbl[i]);

        // Absorbing HALT: random inputs for 20 cycles must not move it or count anything.
        for (int k = 0; k < 20; k++) begin
            step_t s;
            s.name = $sformatf("halt%0d", k);
            s.rst = 1'b0; s.opc = 7'($urandom); s.hc = 1'($urandom); s.bc = 1'($urandom);
            s.mr = 1'($urandom); s.ctl = c_halt; s.ir_cnt = 10;
            run_row(s);
        end

        // Reset clears the halt flag; then start a store and abort it mid-MEM.
        tbl.delete();
        add("rst2",       1, OP_ST, 0, 0, 0, c_zero,    0);
        add("st2.if",     0, OP_ST, 0, 0, 1, c_if_done, 0);
        add("st2.id",     0, OP_ST, 0, 0, 1, c_id,      0);
        add("st2.ex",     0, OP_ST, 0, 0, 0, c_ex_ls,   0);
        foreach (tbl[i]) run_row(tbl[i]);

        reset = 1'b0; opcode = OP_ST; mem_ready = 1'b0;
        #3;
        check("abort.pre_mem_write", {31'd0, mem_write}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("abort.mem_write", {31'd0, mem_write}, 32'd0);
        check("abort.ctl", {15'd0, got_ctl}, 32'd0);
        check("abort.instret", instret, 32'd0);
        @(posedge clk);
        #1;
        tbl.delete();
        add("abort.rst",  1, OP_ST, 0, 0, 0, c_zero,    0);
        add("abort.if",   0, OP_ST, 0, 0, 0, c_if_wait, 0);
        foreach (tbl[i]) run_row(tbl[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
